// File: rtl/cache_mem_arbiter_if.sv
// Bundle carrying the I-cache, D-cache and memory-side signals of cache_mem_arbiter.
// The master modport is the arbiter's view. The slave modport is the caches/memory view.
interface cache_mem_arbiter_if #(
  parameter int LINE_ADDR_LEN = 3
);
  logic                     ic_req;
  logic [31:0]              ic_addr;
  logic                     ic_gnt;
  logic                     ic_rvalid;
  logic [31:0]              ic_rdata;
  logic                     ic_done;

  logic                     dc_req;
  logic                     dc_we;
  logic [31:0]              dc_addr;
  logic [31:0]              dc_wdata;
  logic                     dc_gnt;
  logic                     dc_rvalid;
  logic [31:0]              dc_rdata;
  logic                     dc_done;

  logic [LINE_ADDR_LEN-1:0] xfer_idx;

  logic                     mem_req;
  logic                     mem_we;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;
  logic                     mem_ack;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
    output ic_gnt, ic_rvalid, ic_rdata, ic_done,
    output dc_gnt, dc_rvalid, dc_rdata, dc_done,
    output xfer_idx, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
    input  ic_gnt, ic_rvalid, ic_rdata, ic_done,
    input  dc_gnt, dc_rvalid, dc_rdata, dc_done,
    input  xfer_idx, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Two-client line arbiter that lets the I-cache and D-cache share one word-wide memory port.
// Option ARB_ROUND_ROBIN_EN makes ties alternate. Without it, the D-cache wins every tie.
module cache_mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3
) (
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.master bus
);
  // Purpose: serialises whole-line refills and writebacks of two caches onto one memory port.
  // Latency: grant 1 cycle after request is sampled, one beat per mem_ack, then one DONE cycle.
  // Backpressure: beats stall until mem_ack. Losing requester waits until the arbiter returns to IDLE.

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    state, state_nxt;
  logic                      owner;
  logic                      we_q;
  logic [31:LINE_ADDR_LEN+2] line_q;
  logic [LINE_ADDR_LEN-1:0]  beat;
  logic [31:0]               ic_xfers;
  logic [31:0]               dc_xfers;
  logic                      any_req;
  logic                      pick_dc;
  logic                      last_beat;
  logic                      unused_addr_bits;

  assign any_req   = bus.ic_req | bus.dc_req;
  assign last_beat = (beat == {LINE_ADDR_LEN{1'b1}});
  assign unused_addr_bits = ^{bus.ic_addr[LINE_ADDR_LEN+1:0], bus.dc_addr[LINE_ADDR_LEN+1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  // A tie goes to whoever was not granted last. After reset, last_owner is IC, so DC wins the first tie.
  assign pick_dc = bus.dc_req & (~bus.ic_req | ~last_owner);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_owner <= pick_dc;
    end
  end
`else
  assign pick_dc = bus.dc_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (bus.mem_ack && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      we_q     <= 1'b0;
      line_q   <= '0;
      beat     <= '0;
      ic_xfers <= '0;
      dc_xfers <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner  <= pick_dc;
            we_q   <= pick_dc & bus.dc_we;
            line_q <= pick_dc ? bus.dc_addr[31:LINE_ADDR_LEN+2] : bus.ic_addr[31:LINE_ADDR_LEN+2];
            beat   <= '0;
          end
        end
        BUSY: begin
          if (bus.mem_ack) beat <= beat + 1'b1;
        end
        DONE: begin
          if (owner) dc_xfers <= dc_xfers + 32'd1;
          else       ic_xfers <= ic_xfers + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.xfer_idx = beat;

  always_comb begin
    bus.ic_gnt    = 1'b0;
    bus.ic_rvalid = 1'b0;
    bus.ic_rdata  = '0;
    bus.ic_done   = 1'b0;
    bus.dc_gnt    = 1'b0;
    bus.dc_rvalid = 1'b0;
    bus.dc_rdata  = '0;
    bus.dc_done   = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      BUSY: begin
        bus.ic_gnt   = ~owner;
        bus.dc_gnt   = owner;
        bus.mem_req  = 1'b1;
        bus.mem_we   = we_q;
        bus.mem_addr = {line_q, beat, 2'b00};
        if (we_q) begin
          bus.mem_wdata = bus.dc_wdata;
        end else if (owner) begin
          bus.dc_rvalid = bus.mem_ack;
          bus.dc_rdata  = bus.mem_rdata;
        end else begin
          bus.ic_rvalid = bus.mem_ack;
          bus.ic_rdata  = bus.mem_rdata;
        end
      end
      DONE: begin
        bus.ic_gnt  = ~owner;
        bus.dc_gnt  = owner;
        bus.ic_done = ~owner;
        bus.dc_done = owner;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter with 4-word lines.
// It covers the ARB_ROUND_ROBIN_EN and fixed-priority builds.
module tb_cache_mem_arbiter;
  localparam int LAL = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  cache_mem_arbiter_if #(.LINE_ADDR_LEN(LAL)) bus();
  cache_mem_arbiter #(.LINE_ADDR_LEN(LAL)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the granting edge with the arbiter in BUSY. Returns one step after the DONE edge.
  task automatic do_line(input bit is_dc, input bit we, input logic [31:0] base, input int gap);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("hold_addr", bus.mem_addr, base + 32'(4 * i));
        check("hold_rvalid", 32'({bus.ic_rvalid, bus.dc_rvalid}), 32'd0);
        tick();
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hD00D_0000 + 32'(i);
      bus.dc_wdata  = 32'hA0 + 32'(bus.xfer_idx);
      @(negedge clk);
      check("mem_req", 32'(bus.mem_req), 32'd1);
      check("mem_we", 32'(bus.mem_we), 32'(we));
      check("mem_addr", bus.mem_addr, base + 32'(4 * i));
      check("xfer_idx", 32'(bus.xfer_idx), 32'(i));
      check("gnt", 32'({bus.ic_gnt, bus.dc_gnt}), is_dc ? 32'd1 : 32'd2);
      check("rvalid", 32'({bus.ic_rvalid, bus.dc_rvalid}), we ? 32'd0 : (is_dc ? 32'd1 : 32'd2));
      if (!we) check("rdata", is_dc ? bus.dc_rdata : bus.ic_rdata, 32'hD00D_0000 + 32'(i));
      else     check("mem_wdata", bus.mem_wdata, 32'hA0 + 32'(i));
      check("done_early", 32'({bus.ic_done, bus.dc_done}), 32'd0);
      tick();
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("done_mem_req", 32'(bus.mem_req), 32'd0);
    check("done", 32'({bus.ic_done, bus.dc_done}), is_dc ? 32'd1 : 32'd2);
    check("done_gnt", 32'({bus.ic_gnt, bus.dc_gnt}), is_dc ? 32'd1 : 32'd2);
    tick();
  endtask

  initial begin
    bit exp_dc;
    rst = 1'b1;
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;

    #12;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_gnt", 32'({bus.ic_gnt, bus.dc_gnt}), 32'd0);
    check("rst_rvalid", 32'({bus.ic_rvalid, bus.dc_rvalid}), 32'd0);
    check("rst_done", 32'({bus.ic_done, bus.dc_done}), 32'd0);
    check("rst_xfer_idx", 32'(bus.xfer_idx), 32'd0);
    check("rst_ic_xfers", dut.ic_xfers, 32'd0);
    check("rst_dc_xfers", dut.dc_xfers, 32'd0);
    rst = 1'b0;
    tick();

    // A stray ack in IDLE must not start anything.
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check("spur_mem_req", 32'(bus.mem_req), 32'd0);
    check("spur_rvalid", 32'({bus.ic_rvalid, bus.dc_rvalid}), 32'd0);
    tick();
    @(negedge clk);
    check("spur_xfer_idx", 32'(bus.xfer_idx), 32'd0);
    check("spur_gnt", 32'({bus.ic_gnt, bus.dc_gnt}), 32'd0);

    // I-cache refill with a misaligned address. ic_req is dropped right after the grant.
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1234;
    tick();
    bus.ic_req = 1'b0;
    do_line(1'b0, 1'b0, 32'h0000_1230, 0);
    @(negedge clk);
    check("ic_done_once", 32'(bus.ic_done), 32'd0);
    check("ic_gnt_released", 32'(bus.ic_gnt), 32'd0);
    check("idle_mem_addr", bus.mem_addr, 32'd0);
    check("ic_xfers_1", dut.ic_xfers, 32'd1);
    tick();

    // Both caches request in the same cycle. D-cache goes first, then the I-cache gets the port.
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0100;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h0000_0044;
    tick();
    bus.dc_req = 1'b0;
    do_line(1'b1, 1'b0, 32'h0000_0040, 0);
    @(negedge clk);
    check("gap_idle_gnt", 32'({bus.ic_gnt, bus.dc_gnt}), 32'd0);
    check("gap_idle_req", 32'(bus.mem_req), 32'd0);
    tick();
    bus.ic_req = 1'b0;
    do_line(1'b0, 1'b0, 32'h0000_0100, 0);
    check("dc_xfers_1", dut.dc_xfers, 32'd1);
    check("ic_xfers_2", dut.ic_xfers, 32'd2);

    // D-cache writeback with an ack on every third cycle.
    bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 32'h0000_0080;
    tick();
    bus.dc_req = 1'b0; bus.dc_we = 1'b0;
    do_line(1'b1, 1'b1, 32'h0000_0080, 2);
    @(negedge clk);
    check("wb_idle_we", 32'(bus.mem_we), 32'd0);
    check("wb_idle_wdata", bus.mem_wdata, 32'd0);
    check("dc_xfers_2", dut.dc_xfers, 32'd2);
    tick();

    // Reset arrives during beat 2 of an I-cache refill.
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0400;
    tick();
    bus.ic_req = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("pre_rst_idx", 32'(bus.xfer_idx), 32'd2);
    check("pre_rst_req", 32'(bus.mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", 32'(bus.mem_req), 32'd0);
    check("async_rst_gnt", 32'(bus.ic_gnt), 32'd0);
    check("async_rst_idx", 32'(bus.xfer_idx), 32'd0);
    tick();
    @(negedge clk);
    check("rst_no_done", 32'(bus.ic_done), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("rst_no_done2", 32'(bus.ic_done), 32'd0);
    check("rst_ic_xfers_0", dut.ic_xfers, 32'd0);
    check("rst_dc_xfers_0", dut.dc_xfers, 32'd0);
    tick();
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0400;
    tick();
    bus.ic_req = 1'b0;
    do_line(1'b0, 1'b0, 32'h0000_0400, 0);
    check("restart_ic_xfers", dut.ic_xfers, 32'd1);

    // Both caches request continuously after a fresh reset.
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0300;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_dc = (k % 2 == 0);
`else
      exp_dc = 1'b1;
`endif
      do_line(exp_dc, 1'b0, exp_dc ? 32'h0000_0200 : 32'h0000_0300, 0);
    end
    bus.ic_req = 1'b0; bus.dc_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    check("rr_dc_xfers", dut.dc_xfers, 32'd2);
    check("rr_ic_xfers", dut.ic_xfers, 32'd2);
`else
    check("fp_dc_xfers", dut.dc_xfers, 32'd4);
    check("fp_ic_xfers", dut.ic_xfers, 32'd0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
